// File: rtl/lightbike_dir_queue.sv
// Per-player steering: debounced, edge-detected direction buttons feed a small turn queue,
// and one queued turn per player is applied on each movement tick (reversals rejected).
module lightbike_dir_queue #(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter logic [1:0]  INIT_DIR        = 2'd0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        tick,
  input  logic [NUM_PLAYERS-1:0]      btn_left,
  input  logic [NUM_PLAYERS-1:0]      btn_right,
  input  logic [NUM_PLAYERS-1:0]      btn_up,
  input  logic [NUM_PLAYERS-1:0]      btn_down,
  output logic [2*NUM_PLAYERS-1:0]    dir_code,
  output logic [32*NUM_PLAYERS-1:0]   dir_step,
  output logic [NUM_PLAYERS-1:0]      turn_dropped
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned QcW  = $clog2(QUEUE_DEPTH + 1);

  function automatic logic [31:0] step_of(input logic [1:0] code);
    logic [31:0] s;
    case (code)
      2'd0:    s = 32'd1;
      2'd1:    s = 32'(SCREEN_W);
      2'd2:    s = '1;
      default: s = -32'(SCREEN_W);
    endcase
    return s;
  endfunction

  // Button bit b carries heading code b: 0 right, 1 down, 2 left, 3 up.
  logic [3:0]      raw        [NUM_PLAYERS];
  logic [3:0]      sync1_q    [NUM_PLAYERS];
  logic [3:0]      sync2_q    [NUM_PLAYERS];
  logic [3:0]      deb_q      [NUM_PLAYERS];
  logic [3:0]      deb_d      [NUM_PLAYERS];
  logic [3:0]      deb_prev_q [NUM_PLAYERS];
  logic [CntW-1:0] cnt_q      [NUM_PLAYERS][4];
  logic [CntW-1:0] cnt_d      [NUM_PLAYERS][4];
  logic [1:0]      qmem_q     [NUM_PLAYERS][QUEUE_DEPTH];
  logic [1:0]      qmem_d     [NUM_PLAYERS][QUEUE_DEPTH];
  logic [QcW-1:0]  qcnt_q     [NUM_PLAYERS];
  logic [QcW-1:0]  qcnt_d     [NUM_PLAYERS];
  logic [1:0]      dir_q      [NUM_PLAYERS];
  logic [1:0]      dir_d      [NUM_PLAYERS];
  logic [31:0]     step_q     [NUM_PLAYERS];
  logic [31:0]     step_d     [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] drop_q;
  logic [NUM_PLAYERS-1:0] drop_d;

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      raw[p] = {btn_up[p], btn_left[p], btn_down[p], btn_right[p]};
    end
  end

  always_comb begin
    logic [3:0]     ev;
    logic           push;
    logic           pop;
    logic [1:0]     code;
    logic [1:0]     head;
    logic [QcW-1:0] n;
    ev   = '0;
    push = 1'b0;
    pop  = 1'b0;
    code = 2'd0;
    head = 2'd0;
    n    = '0;
    drop_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      deb_d[p]  = deb_q[p];
      qmem_d[p] = qmem_q[p];
      qcnt_d[p] = qcnt_q[p];
      dir_d[p]  = dir_q[p];
      step_d[p] = step_q[p];

      // Counter runs only while the synced level disagrees with the accepted level.
      for (int b = 0; b < 4; b++) begin
        cnt_d[p][b] = cnt_q[p][b];
        if (sync2_q[p][b] == deb_q[p][b]) begin
          cnt_d[p][b] = '0;
        end else if (cnt_q[p][b] == CntW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[p][b] = sync2_q[p][b];
          cnt_d[p][b] = '0;
        end else begin
          cnt_d[p][b] = cnt_q[p][b] + CntW'(1);
        end
      end

      ev   = deb_q[p] & ~deb_prev_q[p];
      push = |ev;
      if (ev[1])      code = 2'd1;
      else if (ev[3]) code = 2'd3;
      else if (ev[0]) code = 2'd0;
      else            code = 2'd2;

      pop  = tick && (qcnt_q[p] != '0);
      head = qmem_q[p][0];
      if (pop && (head != dir_q[p]) && (head != (dir_q[p] ^ 2'b10))) begin
        dir_d[p]  = head;
        step_d[p] = step_of(head);
      end

      n = qcnt_q[p];
      if (pop) begin
        for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
          qmem_d[p][i] = qmem_q[p][i+1];
        end
        n = n - QcW'(1);
      end
      if (push) begin
        if (n < QcW'(QUEUE_DEPTH)) begin
          for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            if (QcW'(i) == n) qmem_d[p][i] = code;
          end
          n = n + QcW'(1);
        end else begin
          drop_d[p] = 1'b1;
        end
      end
      qcnt_d[p] = n;

      if (clear) begin
        deb_d[p]  = '0;
        for (int b = 0; b < 4; b++) cnt_d[p][b] = '0;
        qcnt_d[p] = '0;
        dir_d[p]  = INIT_DIR;
        step_d[p] = step_of(INIT_DIR);
        drop_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        sync1_q[p]    <= '0;
        sync2_q[p]    <= '0;
        deb_q[p]      <= '0;
        deb_prev_q[p] <= '0;
        qcnt_q[p]     <= '0;
        dir_q[p]      <= INIT_DIR;
        step_q[p]     <= step_of(INIT_DIR);
        for (int b = 0; b < 4; b++) cnt_q[p][b] <= '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) qmem_q[p][i] <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        sync1_q[p]    <= raw[p];
        sync2_q[p]    <= sync1_q[p];
        deb_q[p]      <= deb_d[p];
        deb_prev_q[p] <= clear ? 4'b0 : deb_q[p];
        qcnt_q[p]     <= qcnt_d[p];
        dir_q[p]      <= dir_d[p];
        step_q[p]     <= step_d[p];
        for (int b = 0; b < 4; b++) cnt_q[p][b] <= cnt_d[p][b];
        for (int i = 0; i < QUEUE_DEPTH; i++) qmem_q[p][i] <= qmem_d[p][i];
      end
      drop_q <= drop_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      dir_code[2*p +: 2]  = dir_q[p];
      dir_step[32*p +: 32] = step_q[p];
    end
    turn_dropped = drop_q;
  end

endmodule

// File: tb/tb_lightbike_dir_queue.sv
// Bench for lightbike_dir_queue: directed vector table, hand sequences, and a randomized run
// against a queue-based reference model.
module tb_lightbike_dir_queue;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        tick;
  logic [1:0]  btn_left;
  logic [1:0]  btn_right;
  logic [1:0]  btn_up;
  logic [1:0]  btn_down;
  logic [3:0]  dir_code;
  logic [63:0] dir_step;
  logic [1:0]  turn_dropped;

  int total = 0;
  int bad   = 0;

  lightbike_dir_queue #(
    .NUM_PLAYERS    (2),
    .SCREEN_W       (640),
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH    (2),
    .INIT_DIR       (2'd0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .tick        (tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .dir_code    (dir_code),
    .dir_step    (dir_step),
    .turn_dropped(turn_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         p;
    int         b;
    logic [1:0] e0;
    logic [1:0] e1;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] exp_step(input logic [1:0] c);
    case (c)
      2'd0:    return 32'h0000_0001;
      2'd1:    return 32'h0000_0280;
      2'd2:    return 32'hFFFF_FFFF;
      default: return 32'hFFFF_FD80;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_dirs(input string name, input logic [1:0] e0, input logic [1:0] e1);
    check({name, " code"}, {60'd0, dir_code}, {60'd0, e1, e0});
    check({name, " step"}, dir_step, {exp_step(e1), exp_step(e0)});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Code b: 0 right, 1 down, 2 left, 3 up.
  task automatic set_btn(input int p, input int b, input logic v);
    case (b)
      0:       btn_right[p] = v;
      1:       btn_down[p]  = v;
      2:       btn_left[p]  = v;
      default: btn_up[p]    = v;
    endcase
  endtask

  task automatic press(input int p, input int b);
    set_btn(p, b, 1'b1);
    cyc(10);
    set_btn(p, b, 1'b0);
    cyc(12);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // Reference model state for the randomized run.
  logic [1:0] mq [2][$];
  logic [1:0] mdir [2];
  logic [1:0] mdrop;
  int push_at [2][4];
  int hold    [2][4];
  int idle    [2][4];
  int edge_n;
  int prio [4] = '{1, 3, 0, 2};

  initial begin
    int drops;
    reset = 1'b1; clear = 1'b0; tick = 1'b0;
    btn_left = '0; btn_right = '0; btn_up = '0; btn_down = '0;

    vecs[0]  = '{0, 2, 2'd0, 2'd0};
    vecs[1]  = '{0, 3, 2'd3, 2'd0};
    vecs[2]  = '{0, 1, 2'd3, 2'd0};
    vecs[3]  = '{0, 0, 2'd0, 2'd0};
    vecs[4]  = '{0, 1, 2'd1, 2'd0};
    vecs[5]  = '{0, 1, 2'd1, 2'd0};
    vecs[6]  = '{1, 2, 2'd1, 2'd0};
    vecs[7]  = '{1, 1, 2'd1, 2'd1};
    vecs[8]  = '{0, 2, 2'd2, 2'd1};
    vecs[9]  = '{1, 3, 2'd2, 2'd1};
    vecs[10] = '{1, 0, 2'd2, 2'd0};

    cyc(3);
    reset = 1'b0;
    check_dirs("reset", 2'd0, 2'd0);
    check("reset dropped", {62'd0, turn_dropped}, 64'd0);

    // Short glitch must not enqueue; a long hold pushes once.
    set_btn(0, 3, 1'b1); cyc(3); set_btn(0, 3, 1'b0); cyc(10);
    set_btn(0, 1, 1'b1); cyc(20);
    do_tick();
    check_dirs("hold tick1", 2'd1, 2'd0);
    set_btn(0, 1, 1'b0); cyc(12);
    do_tick();
    check_dirs("hold tick2", 2'd1, 2'd0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      press(vecs[i].p, vecs[i].b);
      do_tick();
      check_dirs($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1);
    end

    // Up then left queued from heading right.
    do_reset();
    press(0, 3); press(0, 2);
    do_tick(); check_dirs("uturn t1", 2'd3, 2'd0);
    do_tick(); check_dirs("uturn t2", 2'd2, 2'd0);

    // Third press overflows the 2-entry queue.
    do_reset();
    press(0, 1); press(0, 2);
    set_btn(0, 3, 1'b1);
    drops = 0;
    repeat (10) begin
      cyc(1);
      if (turn_dropped[0]) drops++;
    end
    set_btn(0, 3, 1'b0); cyc(12);
    check("drop pulse cycles", 64'(drops), 64'd1);
    do_tick(); check_dirs("full t1", 2'd1, 2'd0);
    do_tick(); check_dirs("full t2", 2'd2, 2'd0);
    do_tick(); check_dirs("full t3", 2'd2, 2'd0);

    // Both players at once, then clear with entries still queued.
    do_reset();
    set_btn(0, 1, 1'b1); set_btn(1, 3, 1'b1); cyc(10);
    set_btn(0, 1, 1'b0); set_btn(1, 3, 1'b0); cyc(12);
    set_btn(0, 3, 1'b1); set_btn(1, 1, 1'b1); cyc(10);
    set_btn(0, 3, 1'b0); set_btn(1, 1, 1'b0); cyc(12);
    do_tick(); check_dirs("dual t1", 2'd1, 2'd3);
    clear = 1'b1; cyc(1); clear = 1'b0;
    check_dirs("clear", 2'd0, 2'd0);
    do_tick(); check_dirs("after clear", 2'd0, 2'd0);

    // Simultaneous down+left: only down survives.
    do_reset();
    set_btn(0, 1, 1'b1); set_btn(0, 2, 1'b1); cyc(10);
    set_btn(0, 1, 1'b0); set_btn(0, 2, 1'b0); cyc(12);
    do_tick(); check_dirs("prio t1", 2'd1, 2'd0);
    do_tick(); check_dirs("prio t2", 2'd1, 2'd0);

    // Randomized run against the reference model.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      mq[p].delete();
      mdir[p] = 2'd0;
      for (int b = 0; b < 4; b++) begin
        push_at[p][b] = -1; hold[p][b] = 0; idle[p][b] = 10;
      end
    end
    edge_n = 0;
    repeat (3000) begin
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < 4; b++) begin
          if (hold[p][b] > 0) begin
            hold[p][b]--;
            if (hold[p][b] == 0) begin
              set_btn(p, b, 1'b0);
              idle[p][b] = 0;
            end
          end else begin
            idle[p][b]++;
            if (idle[p][b] >= 10 && $urandom_range(0, 24) == 0) begin
              set_btn(p, b, 1'b1);
              hold[p][b] = $urandom_range(8, 15);
              // Sampled at the next edge; enqueued 2 + 4 + 1 edges after that.
              push_at[p][b] = edge_n + 7;
            end
          end
        end
      end
      tick = ($urandom_range(0, 3) == 0);
      @(posedge clock);
      edge_n++;
      for (int p = 0; p < 2; p++) begin
        int code;
        logic [1:0] h;
        code = -1;
        for (int k = 0; k < 4; k++) begin
          if (code < 0 && push_at[p][prio[k]] == edge_n) code = prio[k];
        end
        mdrop[p] = 1'b0;
        if (tick && mq[p].size() > 0) begin
          h = mq[p].pop_front();
          if (h != mdir[p] && h != (mdir[p] ^ 2'b10)) mdir[p] = h;
        end
        if (code >= 0) begin
          if (mq[p].size() < 2) mq[p].push_back(code[1:0]);
          else mdrop[p] = 1'b1;
        end
      end
      #1;
      check("rnd code", {60'd0, dir_code}, {60'd0, mdir[1], mdir[0]});
      check("rnd step", dir_step, {exp_step(mdir[1]), exp_step(mdir[0])});
      check("rnd dropped", {62'd0, turn_dropped}, {62'd0, mdrop});
    end
    tick = 1'b0;
    btn_left = '0; btn_right = '0; btn_up = '0; btn_down = '0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
